// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Multi-cycle unsigned adder. Adds two WIDTH-bit operands plus a
//             carry-in, DIGIT bits per clock, with a registered carry between
//             digits. A start/busy/done handshake lets datapaths trade area
//             for latency (WIDTH/DIGIT + 1 cycles per result).
//  Ports    : clk   - clock, all state updates on the rising edge
//             rst   - synchronous active-high reset, overrides everything
//             start - request a new addition (honoured in IDLE or DONE only)
//             a, b  - WIDTH-bit operands, captured on an accepted start
//             cin   - carry-in, captured on an accepted start
//             busy  - high while digits are being processed (RUN)
//             done  - one-cycle pulse, s/cout valid
//             s     - sum, held from done until the next done or reset
//             cout  - carry-out, held with s
//             ovf   - signed overflow, held with s
//                     (present only with SERIAL_ADDER_OVF_EN defined)
//  Options  : `define SERIAL_ADDER_OVF_EN to add the ovf output.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Reject illegal configurations at elaboration time.
  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CNT_W-1:0] count;

`ifdef SERIAL_ADDER_OVF_EN
  // Operand sign bits are shifted out of a_sh/b_sh, so keep copies.
  logic             a_msb;
  logic             b_msb;
`endif

  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] digit_ext;
  logic [WIDTH-1:0] res_next;

  // One digit of the sum per cycle; the new digit enters at the MSB end so
  // that after N cycles the first (least significant) digit sits at bit 0.
  always_comb begin
    digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    digit_ext = '0;
    digit_ext[DIGIT-1:0] = digit_sum[DIGIT-1:0];
    // With DIGIT == WIDTH the shift-out term is zero and the digit fills s.
    res_next = (res_sh >> DIGIT) | (digit_ext << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      s      <= '0;
      cout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        // DONE behaves like IDLE for start acceptance, giving back-to-back
        // operation without an idle gap.
        IDLE, DONE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            res_sh <= '0;
            count  <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end

        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          carry  <= digit_sum[DIGIT];
          res_sh <= res_next;
          count  <= count + 1'b1;
          if (count == LAST) begin
            // Results are published only here, so s/cout stay stable
            // through IDLE and any following RUN.
            s     <= res_next;
            cout  <= digit_sum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Scoreboard bench for serial_adder. Two instances (DIGIT=1 and
//             DIGIT=4, WIDTH=8) receive directed vectors; expected results
//             are queued at issue time and popped by per-instance monitors
//             whenever done is seen. Handshake timing and hold behaviour are
//             checked inline by the stimulus process.
//  Options  : SERIAL_ADDER_OVF_EN also checks the ovf output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start1, start4;
  logic [7:0] a1, b1, a4, b4;
  logic       cin1, cin4;
  logic       busy1, done1, cout1;
  logic       busy4, done4, cout4;
  logic [7:0] s1, s4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf1, ovf4;
`endif

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int vectors     = 0;
  int miscompares = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // ---------------- monitors ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("d1 spurious done", 32'(done1), 32'd0);
      end else begin
        e = q1.pop_front();
        check("d1 s", 32'(s1), 32'(e.s));
        check("d1 cout", 32'(cout1), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
        check("d1 ovf", 32'(ovf1), 32'(e.ovf));
`endif
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        check("d4 spurious done", 32'(done4), 32'd0);
      end else begin
        e = q4.pop_front();
        check("d4 s", 32'(s4), 32'(e.s));
        check("d4 cout", 32'(cout4), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
        check("d4 ovf", 32'(ovf4), 32'(e.ovf));
`endif
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int sel, logic st, logic [7:0] a, logic [7:0] b, logic c);
    if (sel == 0) begin
      start1 = st; a1 = a; b1 = b; cin1 = c;
    end else begin
      start4 = st; a4 = a; b4 = b; cin4 = c;
    end
  endtask

  // Raise start for one edge (or leave it high if keep), queue the expected
  // result. Returns in the first RUN cycle.
  task automatic issue(int sel, logic [7:0] a, logic [7:0] b, logic c,
                       exp_t e, bit push, bit keep);
    drive(sel, 1'b1, a, b, c);
    if (push) begin
      if (sel == 0) q1.push_back(e);
      else          q4.push_back(e);
    end
    tick();
    if (!keep) drive(sel, 1'b0, 8'hA5, 8'h5A, 1'b1);  // scramble inputs after capture
  endtask

  // Check n busy cycles with s held, then the done cycle.
  task automatic run_phase(int sel, int n, logic [7:0] held, string tag);
    for (int i = 0; i < n; i++) begin
      check({tag, " busy"}, 32'(sel == 0 ? busy1 : busy4), 32'd1);
      check({tag, " done low"}, 32'(sel == 0 ? done1 : done4), 32'd0);
      check({tag, " s held"}, 32'(sel == 0 ? s1 : s4), 32'(held));
      tick();
    end
    check({tag, " done"}, 32'(sel == 0 ? done1 : done4), 32'd1);
    check({tag, " busy low"}, 32'(sel == 0 ? busy1 : busy4), 32'd0);
  endtask

  task automatic idle_check(int sel, logic [7:0] held, string tag);
    tick();
    check({tag, " idle done"}, 32'(sel == 0 ? done1 : done4), 32'd0);
    check({tag, " idle busy"}, 32'(sel == 0 ? busy1 : busy4), 32'd0);
    check({tag, " idle s"}, 32'(sel == 0 ? s1 : s4), 32'(held));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
    drive(1, 1'b0, 8'd0, 8'd0, 1'b0);
    tick();
    tick();
    check("reset busy", 32'({busy1, busy4}), 32'd0);
    check("reset done", 32'({done1, done4}), 32'd0);
    check("reset s", 32'({s1, s4}), 32'd0);
    check("reset cout", 32'({cout1, cout4}), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset ovf", 32'({ovf1, ovf4}), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // DIGIT=1: eight busy cycles then done.
    issue(0, 8'd3, 8'd5, 1'b0, '{8'd8, 1'b0, 1'b0}, 1, 0);
    run_phase(0, 8, 8'd0, "3+5");
    idle_check(0, 8'd8, "3+5");

    issue(0, 8'd255, 8'd1, 1'b0, '{8'd0, 1'b1, 1'b0}, 1, 0);
    run_phase(0, 8, 8'd8, "255+1");
    idle_check(0, 8'd0, "255+1");

    issue(0, 8'd0, 8'd0, 1'b1, '{8'd1, 1'b0, 1'b0}, 1, 0);
    run_phase(0, 8, 8'd0, "0+0+1");
    idle_check(0, 8'd1, "0+0+1");

    issue(0, 8'd127, 8'd1, 1'b0, '{8'd128, 1'b0, 1'b1}, 1, 0);
    run_phase(0, 8, 8'd1, "127+1");
    idle_check(0, 8'd128, "127+1");

    issue(0, 8'd200, 8'd100, 1'b0, '{8'd44, 1'b1, 1'b0}, 1, 0);
    run_phase(0, 8, 8'd128, "200+100");
    idle_check(0, 8'd44, "200+100");

    // start held high through RUN is ignored; held in DONE it launches the
    // next operation immediately with the operands present then.
    issue(0, 8'h10, 8'h20, 1'b0, '{8'h30, 1'b0, 1'b0}, 1, 1);
    drive(0, 1'b1, 8'h11, 8'h22, 1'b0);
    q1.push_back('{8'h33, 1'b0, 1'b0});
    run_phase(0, 8, 8'd44, "b2b first");
    tick();
    drive(0, 1'b0, 8'hFF, 8'hFF, 1'b1);
    run_phase(0, 8, 8'h30, "b2b second");
    idle_check(0, 8'h33, "b2b second");

    // Reset in the middle of an operation: no done, outputs cleared.
    issue(0, 8'h55, 8'h55, 1'b0, '{8'hAA, 1'b0, 1'b1}, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    check("midrst busy before", 32'(busy1), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy", 32'(busy1), 32'd0);
    check("midrst done", 32'(done1), 32'd0);
    check("midrst s", 32'(s1), 32'd0);
    check("midrst cout", 32'(cout1), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("midrst ovf", 32'(ovf1), 32'd0);
`endif
    for (int i = 0; i < 10; i++) begin
      tick();
      check("midrst no done", 32'(done1), 32'd0);
    end

    // DIGIT=4: two busy cycles then done.
    issue(1, 8'h9C, 8'h7B, 1'b1, '{8'h18, 1'b1, 1'b0}, 1, 0);
    run_phase(1, 2, 8'h00, "9C+7B+1");
    idle_check(1, 8'h18, "9C+7B+1");

    issue(1, 8'hF0, 8'hF0, 1'b0, '{8'hE0, 1'b1, 1'b0}, 1, 0);
    run_phase(1, 2, 8'h18, "F0+F0");
    idle_check(1, 8'hE0, "F0+F0");

    issue(1, 8'h80, 8'h80, 1'b0, '{8'h00, 1'b1, 1'b1}, 1, 0);
    run_phase(1, 2, 8'hE0, "80+80");
    idle_check(1, 8'h00, "80+80");

    tick();
    check("d1 queue drained", 32'(q1.size()), 32'd0);
    check("d4 queue drained", 32'(q4.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
